// File: rtl/div113_pkg.sv
// Shared constants and types for the iterative divide-by-113 controller.
package div113_pkg;

   localparam int unsigned DIVISOR = 113;
   localparam int unsigned DW      = 24;
   localparam int unsigned DIGIT_W = 2;
   localparam int unsigned REM_W   = 7;
   localparam int unsigned STEPS   = DW / DIGIT_W;
   localparam int unsigned CNT_W   = $clog2(STEPS);
   // Quotient digit is 3 bits wide so an illegal remainder shows up in the MSB.
   localparam int unsigned QD_W    = 3;

   typedef logic [REM_W-1:0] rem_t;

   typedef struct packed {
      rem_t                 rem;
      logic [DIGIT_W-1:0]   digit;
   } step_in_t;

   typedef struct packed {
      logic [QD_W-1:0]      q;
      rem_t                 rem;
   } step_out_t;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

endpackage

// File: rtl/div113_step.sv
// Combinational radix-4 step: {rem, digit} -> {q_digit, rem_next} for divisor 113.
module div113_step
   import div113_pkg::*;
(
   input  step_in_t  step_i,
   output step_out_t step_o
);

   localparam int unsigned VW = REM_W + DIGIT_W;
   localparam logic [VW-1:0] M1 = VW'(DIVISOR);
   localparam logic [VW-1:0] M2 = VW'(2 * DIVISOR);
   localparam logic [VW-1:0] M3 = VW'(3 * DIVISOR);
   localparam logic [VW-1:0] M4 = VW'(4 * DIVISOR);

   logic [VW-1:0] val;

   // Subtract the largest multiple of the divisor that fits; q=4 only for an illegal remainder.
   always_comb begin
      val    = step_i;
      step_o = '0;
      if (val >= M4) begin
         step_o.q   = 3'd4;
         step_o.rem = rem_t'(val - M4);
      end else if (val >= M3) begin
         step_o.q   = 3'd3;
         step_o.rem = rem_t'(val - M3);
      end else if (val >= M2) begin
         step_o.q   = 3'd2;
         step_o.rem = rem_t'(val - M2);
      end else if (val >= M1) begin
         step_o.q   = 3'd1;
         step_o.rem = rem_t'(val - M1);
      end else begin
         step_o.q   = 3'd0;
         step_o.rem = rem_t'(val);
      end
   end

endmodule

// File: rtl/div113_seq_ctrl.sv
// Iterative divide-by-113 controller: valid/ready in, 12 radix-4 steps, valid/ready out.
module div113_seq_ctrl
   import div113_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_quot,
   output logic [REM_W-1:0] out_rem,
   output logic          busy
);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]       shreg_q, shreg_d;
   logic [DW-1:0]       quot_q, quot_d;
   rem_t                rem_q, rem_d;

   step_in_t            step_in;
   step_out_t           step_out;

   assign step_in.rem   = rem_q;
   assign step_in.digit = shreg_q[DW-1 -: DIGIT_W];

   div113_step u_step (
      .step_i (step_in),
      .step_o (step_out)
   );

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
      out_valid = (state_q == StDone);
      busy      = (state_q == StRun);

      unique case (state_q)
         StIdle, StDone: begin
            if (in_valid && in_ready) begin
               state_d = StRun;
               shreg_d = in_data;
               quot_d  = '0;
               rem_d   = '0;
               cnt_d   = '0;
            end else if (state_q == StDone && out_ready) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            rem_d   = step_out.rem;
            shreg_d = {shreg_q[DW-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
            quot_d  = {quot_q[DW-DIGIT_W-1:0], step_out.q[DIGIT_W-1:0]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         shreg_q <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   assign out_quot = quot_q;
   assign out_rem  = rem_q;

   // Running remainder must stay below the divisor, so a quotient digit never exceeds 3.
   a_qdigit_legal: assert property (@(posedge clk) disable iff (!rst_n) step_out.q[QD_W-1] == 1'b0);
   a_rem_legal:    assert property (@(posedge clk) disable iff (!rst_n) rem_q < rem_t'(DIVISOR));

endmodule
